// File: rtl/mips_host_loader.sv
// mips_host_loader
// Host-side program loader and debug controller for the pipelined MIPS32 core.
// The host sends one command at a time over a valid/ready channel. Each command
// returns exactly one response word over a second valid/ready channel.
//   WRMEM : one-cycle write strobe into the core's instruction memory
//   RDREG : two-cycle read of the core's register file
//   RUN   : clear the core, release it, and wait for HALTED or a timeout
//   ID    : return the constant 32'h4D49_5053 ("MIPS")
// Ports
//   clk1, rst                  clock, asynchronous active-high reset
//   cmd_valid/ready/op/addr/data   host command channel
//   rsp_valid/ready/data       host response channel
//   mem_we/addr/wdata          instruction-memory write port
//   reg_raddr, reg_rdata       register-file read port (data one cycle late)
//   cpu_hold, cpu_clear        core stall and one-cycle clear pulse
//   cpu_halted                 core HALTED flag
module mips_host_loader #(
   parameter int ADDR_W  = 10,
   parameter int REG_AW  = 5,
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 16
) (
   input  logic              clk1,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [31:0]       cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_data,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [REG_AW-1:0] reg_raddr,
   input  logic [31:0]       reg_rdata,
   output logic              cpu_hold,
   output logic              cpu_clear,
   input  logic              cpu_halted
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_WR   = 3'd1;
   localparam logic [2:0] S_RD0  = 3'd2;
   localparam logic [2:0] S_RD1  = 3'd3;
   localparam logic [2:0] S_CLR  = 3'd4;
   localparam logic [2:0] S_RUN  = 3'd5;
   localparam logic [2:0] S_RSP  = 3'd6;

   localparam logic [1:0] OP_WRMEM = 2'd0;
   localparam logic [1:0] OP_RDREG = 2'd1;
   localparam logic [1:0] OP_RUN   = 2'd2;
   localparam logic [1:0] OP_ID    = 2'd3;

   localparam logic [31:0]      ID_WORD   = 32'h4D49_5053;
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   logic [2:0]        state;
   logic              ready_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       data_q;
   logic [CNT_W-1:0]  count;
   logic [31:0]       rsp_q;
   logic [CNT_W-1:0]  count_inc;
   logic [31:0]       count_word;

   // The response count includes the cycle currently being evaluated, so the
   // halt/timeout decisions look at the already-incremented value.
   assign count_inc  = (count == CNT_MAX) ? count : count + CNT_W'(1);
   assign count_word = 32'(count_inc);

   assign cmd_ready = ready_q;
   assign rsp_valid = (state == S_RSP);
   assign rsp_data  = rsp_q;
   assign mem_we    = (state == S_WR);
   assign mem_addr  = addr_q;
   assign mem_wdata = data_q;
   assign reg_raddr = addr_q[REG_AW-1:0];
   assign cpu_clear = (state == S_CLR);
   // Derived from state so that an asynchronous reset freezes the core at once.
   assign cpu_hold  = (state != S_RUN);

   // cmd_ready is a register so that it stays low throughout reset and rises
   // only after the first clock edge following release.
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         ready_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         count   <= '0;
         rsp_q   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_valid && ready_q) begin
                  ready_q <= 1'b0;
                  addr_q  <= cmd_addr;
                  case (cmd_op)
                     OP_WRMEM: begin
                        data_q <= cmd_data;
                        state  <= S_WR;
                     end
                     OP_RDREG: state <= S_RD0;
                     OP_RUN:   state <= S_CLR;
                     OP_ID: begin
                        rsp_q <= ID_WORD;
                        state <= S_RSP;
                     end
                     default:  state <= S_IDLE;
                  endcase
               end else begin
                  ready_q <= 1'b1;
               end
            end
            S_WR: begin
               rsp_q <= 32'd0;
               state <= S_RSP;
            end
            S_RD0: state <= S_RD1;
            S_RD1: begin
               rsp_q <= reg_rdata;
               state <= S_RSP;
            end
            // HALTED may still be set from the previous run here; it is
            // ignored until the core has seen the clear pulse.
            S_CLR: begin
               count <= '0;
               state <= S_RUN;
            end
            // Halt is tested before timeout so that a tie reports success.
            S_RUN: begin
               count <= count_inc;
               if (cpu_halted) begin
                  rsp_q <= count_word;
                  state <= S_RSP;
               end else if (count_inc >= TIMEOUT_C) begin
                  rsp_q <= 32'h8000_0000 | count_word;
                  state <= S_RSP;
               end
            end
            S_RSP: begin
               if (rsp_ready) begin
                  state   <= S_IDLE;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               state   <= S_IDLE;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mips_host_loader.sv
// tb_mips_host_loader
// Self-checking bench for mips_host_loader. A small behavioural core model
// (instruction image, register file, program interpreter, HALTED timer) sits
// behind the loader. Expected responses and memory writes are queued when each
// command is issued and compared by a single negedge monitor.
module tb_mips_host_loader;

   localparam int TMO = 32;

   logic        clk1;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [9:0]  cmd_addr;
   logic [31:0] cmd_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [4:0]  reg_raddr;
   logic [31:0] reg_rdata;
   logic        cpu_hold;
   logic        cpu_clear;
   logic        cpu_halted;

   mips_host_loader #(
      .ADDR_W (10),
      .REG_AW (5),
      .TIMEOUT(TMO),
      .CNT_W  (16)
   ) dut (
      .clk1      (clk1),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_addr  (cmd_addr),
      .cmd_data  (cmd_data),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .reg_raddr (reg_raddr),
      .reg_rdata (reg_rdata),
      .cpu_hold  (cpu_hold),
      .cpu_clear (cpu_clear),
      .cpu_halted(cpu_halted)
   );

   initial clk1 = 1'b0;
   always #5 clk1 = ~clk1;

   int checks   = 0;
   int failures = 0;

   // Bench-side model state
   logic [31:0] imem [1024];
   logic [31:0] core_regs [32];
   int          halt_after = 0;
   int          core_cnt   = 0;
   logic        core_halted = 1'b0;
   logic [31:0] exp_rsp [$];
   logic [9:0]  exp_wa [$];
   logic [31:0] exp_wd [$];

   // Monitor-side observations
   int          hold_low  = 0;
   int          clear_cnt = 0;
   int          rsp_seen  = 0;
   logic [31:0] last_rsp  = 32'd0;
   logic [31:0] prev_rsp  = 32'd0;
   logic        prev_stall = 1'b0;

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         failures++;
         $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
      end
   endtask

   // Core model: register file read is one cycle late; HALTED rises so that
   // it is seen during the halt_after-th cycle with cpu_hold low.
   assign cpu_halted = core_halted;
   always @(posedge clk1) begin
      reg_rdata <= core_regs[reg_raddr];
      if (cpu_clear) begin
         core_cnt    <= 0;
         core_halted <= 1'b0;
      end else if (!cpu_hold) begin
         core_cnt <= core_cnt + 1;
         if (halt_after != 0 && core_cnt + 2 >= halt_after)
            core_halted <= 1'b1;
      end
   end

   // Architectural effect of running the image: ADD (op 0), ADDI (op 0x0A),
   // halt on op 0x3F, everything else is a no-op.
   task automatic run_program();
      logic [31:0] w;
      int pc = 0;
      for (int n = 0; n < 1024; n++) begin
         w = imem[pc];
         if (w[31:26] === 6'h3f) break;
         if (w[31:26] === 6'h00)
            core_regs[w[15:11]] = core_regs[w[25:21]] + core_regs[w[20:16]];
         else if (w[31:26] === 6'h0a)
            core_regs[w[20:16]] = core_regs[w[25:21]] + {{16{w[15]}}, w[15:0]};
         pc = (pc + 1) % 1024;
      end
   endtask

   // Compare process: every cycle out of reset
   always @(negedge clk1) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (!cpu_hold) hold_low++;
         if (cpu_clear) begin
            clear_cnt++;
            check_output("hold_during_clear", 32'(cpu_hold), 32'd1);
         end
         if (mem_we) begin
            check_output("hold_during_we", 32'(cpu_hold), 32'd1);
            if (exp_wa.size() == 0) begin
               check_output("mem_we_extra", 32'd1, 32'd0);
            end else begin
               check_output("mem_addr", 32'(mem_addr), 32'(exp_wa.pop_front()));
               check_output("mem_wdata", mem_wdata, exp_wd.pop_front());
            end
         end
         if (rsp_valid) begin
            check_output("cmd_ready_in_rsp", 32'(cmd_ready), 32'd0);
            if (prev_stall) check_output("rsp_stable", rsp_data, prev_rsp);
            if (rsp_ready) begin
               if (exp_rsp.size() == 0) begin
                  check_output("rsp_extra", 32'd1, 32'd0);
               end else begin
                  check_output("rsp_data", rsp_data, exp_rsp.pop_front());
               end
               last_rsp = rsp_data;
               rsp_seen++;
            end
            prev_stall = !rsp_ready;
            prev_rsp   = rsp_data;
         end else begin
            prev_stall = 1'b0;
         end
      end
   end

   // Presents one command, waits for acceptance, and stalls the response
   // channel for 'stall' cycles before accepting the response.
   task automatic apply_stimulus(input logic [1:0] op, input logic [9:0] addr,
                                 input logic [31:0] data, input int h,
                                 input int stall);
      int seen0;
      int exp_low;
      bit ok;
      case (op)
         2'd0: begin
            imem[addr] = data;
            exp_wa.push_back(addr);
            exp_wd.push_back(data);
            exp_rsp.push_back(32'd0);
         end
         2'd1: exp_rsp.push_back(core_regs[addr[4:0]]);
         2'd2: begin
            halt_after = h;
            run_program();
            if (h != 0 && h <= TMO) exp_rsp.push_back(32'(h));
            else exp_rsp.push_back(32'h8000_0000 | 32'(TMO));
         end
         default: exp_rsp.push_back(32'h4D49_5053);
      endcase
      exp_low   = (h != 0 && h <= TMO) ? h : TMO;
      hold_low  = 0;
      clear_cnt = 0;
      seen0     = rsp_seen;
      @(posedge clk1);
      #1;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = addr;
      cmd_data  = data;
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk1);
         if (cmd_ready) begin ok = 1; break; end
      end
      if (!ok) check_output("cmd_accept_timeout", 32'd0, 32'd1);
      @(posedge clk1);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_data  = $urandom;
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk1);
         if (rsp_valid) begin ok = 1; break; end
      end
      if (!ok) check_output("rsp_valid_timeout", 32'd0, 32'd1);
      repeat (stall) @(negedge clk1);
      @(posedge clk1);
      #1;
      rsp_ready = 1'b1;
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk1);
         if (rsp_seen != seen0) begin ok = 1; break; end
      end
      if (!ok) check_output("rsp_handshake_timeout", 32'd0, 32'd1);
      @(posedge clk1);
      #1;
      rsp_ready = 1'b0;
      if (op == 2'd2) begin
         check_output("run_hold_low_cycles", 32'(hold_low), 32'(exp_low));
         check_output("run_clear_pulses", 32'(clear_cnt), 32'd1);
      end else begin
         check_output("hold_low_cycles", 32'(hold_low), 32'd0);
         check_output("clear_pulses", 32'(clear_cnt), 32'd0);
      end
   endtask

   logic [31:0] prog [9];
   initial begin
      prog[0] = 32'h2801000a; prog[1] = 32'h28020014; prog[2] = 32'h28030019;
      prog[3] = 32'h0ce77800; prog[4] = 32'h0ce77800; prog[5] = 32'h00222000;
      prog[6] = 32'h0ce77800; prog[7] = 32'h00832800; prog[8] = 32'hfc000000;
      for (int i = 0; i < 1024; i++) imem[i] = 32'd0;
      core_regs[0] = 32'd0;
      for (int i = 1; i < 32; i++) core_regs[i] = $urandom;

      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = '0;
      cmd_data = '0; rsp_ready = 1'b0;
      repeat (3) @(negedge clk1);
      check_output("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      check_output("rst_cpu_hold", 32'(cpu_hold), 32'd1);
      check_output("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_output("rst_mem_we", 32'(mem_we), 32'd0);
      check_output("rst_cpu_clear", 32'(cpu_clear), 32'd0);
      check_output("rst_rsp_data", rsp_data, 32'd0);
      @(posedge clk1); #1; rst = 1'b0;
      @(posedge clk1); @(negedge clk1);
      check_output("ready_after_rst", 32'(cmd_ready), 32'd1);

      // ID
      apply_stimulus(2'd3, 10'($urandom), $urandom, 0, 0);
      check_output("id_literal", last_rsp, 32'h4D495053);

      // ADD program
      for (int i = 0; i < 9; i++) apply_stimulus(2'd0, 10'(i), prog[i], 0, 0);
      check_output("wr_literal", last_rsp, 32'd0);

      // RUN halting after 14 cycles, then register readback
      apply_stimulus(2'd2, '0, $urandom, 14, 0);
      check_output("run14_literal", last_rsp, 32'd14);
      apply_stimulus(2'd1, 10'h3e4, $urandom, 0, 1);
      check_output("r4_literal", last_rsp, 32'd30);
      apply_stimulus(2'd1, 10'h005, $urandom, 0, 0);
      check_output("r5_literal", last_rsp, 32'd55);

      // RUN that never halts, and the halt/timeout tie and its neighbours
      apply_stimulus(2'd2, '0, $urandom, 0, 0);
      check_output("timeout_literal", last_rsp, 32'h80000020);
      check_output("hold_after_timeout", 32'(cpu_hold), 32'd1);
      apply_stimulus(2'd2, '0, $urandom, 32, 0);
      check_output("tie_literal", last_rsp, 32'd32);
      apply_stimulus(2'd2, '0, $urandom, 31, 2);
      apply_stimulus(2'd2, '0, $urandom, 33, 0);

      // Randomized traffic
      for (int n = 0; n < 40; n++) begin
         logic [1:0] op;
         int h;
         op = 2'($urandom_range(0, 3));
         h  = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(2, 40));
         if (op == 2'd0)
            apply_stimulus(op, 10'($urandom_range(16, 1023)), $urandom, 0,
                           int'($urandom_range(0, 3)));
         else
            apply_stimulus(op, 10'($urandom), $urandom, h,
                           int'($urandom_range(0, 3)));
      end

      // Response stalled for 5 cycles
      apply_stimulus(2'd3, '0, $urandom, 0, 5);
      check_output("stall_id_literal", last_rsp, 32'h4D495053);

      // Reset in the middle of a RUN
      halt_after = 0;
      @(posedge clk1); #1;
      cmd_valid = 1'b1; cmd_op = 2'd2;
      begin
         bit ok;
         ok = 0;
         for (int i = 0; i < 50; i++) begin
            @(negedge clk1);
            if (cmd_ready) begin ok = 1; break; end
         end
         if (!ok) check_output("run_accept_timeout", 32'd0, 32'd1);
      end
      @(posedge clk1); #1; cmd_valid = 1'b0;
      repeat (6) @(negedge clk1);
      check_output("midrun_hold_low", 32'(cpu_hold), 32'd0);
      #1; rst = 1'b1;
      #1;
      check_output("midrun_rst_hold", 32'(cpu_hold), 32'd1);
      check_output("midrun_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_output("midrun_rst_ready", 32'(cmd_ready), 32'd0);
      exp_rsp.delete();
      clear_cnt = 0;
      repeat (2) @(posedge clk1);
      #1; rst = 1'b0;
      repeat (3) @(negedge clk1);
      check_output("post_rst_clear", 32'(clear_cnt), 32'd0);
      check_output("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      apply_stimulus(2'd3, '0, $urandom, 0, 0);
      check_output("post_rst_id", last_rsp, 32'h4D495053);

      check_output("rsp_queue_drained", 32'(exp_rsp.size()), 32'd0);
      check_output("wr_queue_drained", 32'(exp_wa.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
